pwm_phase_gen: RTL and testbench
================================

// Module: pwm_phase_gen
// PURPOSE
//   Consumes the Johnson counter's thermometer state (2*WIDTH phases per period).
//   Decodes it to a phase index and compares that index against a double-buffered duty value.
//   Drives a complementary PWM pair with programmable dead-time.
//   Sits directly downstream of the Johnson counter; the counter is the PWM timebase.
// PARAMETERS
//   WIDTH     8  Johnson counter width; period P = 2*WIDTH phases (16)
//   DEADTIME  1  cycles both outputs held low after any raw edge (0..7)
// PORTS
//   clk           in   1                clock, all state on rising edge
//   rst_n         in   1                reset, asynchronous, ACTIVE-HIGH (1 = reset)
//   jc_state      in   WIDTH            Johnson counter state, sampled every cycle
//   duty          in   $clog2(P+1)      requested high phases per period (0..P)
//   duty_valid    in   1                duty offered
//   duty_ready    out  1                shadow register empty, duty accepted when valid&ready
//   pwm_hi        out  1                high-side PWM
//   pwm_lo        out  1                low-side PWM (complement with dead-time)
//   period_start  out  1                1-cycle pulse when decoded phase wraps P-1 -> 0
//   code_err      out  1                1-cycle pulse, illegal Johnson code sampled
// BEHAVIOUR
//   - Reset (rst_n=1): pwm_hi=0, pwm_lo=0, period_start=0, code_err=0.
//     duty_active=0, shadow empty so duty_ready=1, phase_q=0, dead-time counter=0.
//     Reset mid-period discards the shadow and active duty immediately.
//   - Decode, stage 1 (registered): jc_state[0] is the first bit to fill.
//     Legal code k<=WIDTH: bits[0..k-1]=1, rest 0 -> phase k.
//     Legal code k>WIDTH: bits[0..k-WIDTH-1]=0, rest 1 -> phase k.
//     All-zero = phase 0; all-ones = phase WIDTH.
//   - Illegal (non-thermometer) code: code_err pulses next cycle; phase_q holds its last value.
//     raw is forced 0 while the code stays illegal. No period_start is generated.
//   - period_start: registered; asserts for one cycle when phase_q goes P-1 -> 0.
//     A repeated phase (stalled counter) never pulses.
//   - Duty handshake: duty_ready = ~shadow_full.
//     On valid&ready, shadow <= min(duty,P) and shadow_full <= 1. Values > P clamp to P.
//     On the period_start cycle with shadow_full=1: duty_active <= shadow, shadow_full <= 0.
//     Accept coinciding with period_start while the shadow is empty: the value goes to the shadow and applies next period.
//     duty_active never changes mid-period.
//   - Compare, stage 2 (registered): raw = (phase_q < duty_active) & code_ok.
//     duty 0 -> raw constantly 0. duty P -> raw constantly 1, no edges, no dead-time gaps.
//   - Dead-time: on any raw edge both outputs drop to 0 that cycle and the counter loads DEADTIME.
//     When the counter reaches 0, pwm_hi=raw and pwm_lo=~raw.
//     DEADTIME=0: pwm_hi=raw and pwm_lo=~raw with no gap.
//     Invariant: pwm_hi & pwm_lo is never 1.
//     A raw edge during an active gap reloads the counter (gap extends).
//   - Latency: jc_state change -> raw change = 2 cycles; -> pwm_hi rise = 2+DEADTIME cycles.
//   - After reset release the outputs sit at pwm_lo=1 once the gap elapses; duty_active=0.
// STRUCTURE
//   pwm_pkg:
//     - localparam function for phase width clog2(2*WIDTH+1)
//     - DEADTIME counter width constant
//     - typedef phase_t
//   Sub-module deadtime_gen:
//     - inputs clk, rst_n, raw
//     - outputs pwm_hi, pwm_lo
//     - parameter DEADTIME
//     - holds the gap counter and the complementary-output invariant
//   Johnson decode/legality check and the duty shadow/active registers stay in pwm_phase_gen.
// TESTING
//   1. Drive the free-running Johnson sequence (WIDTH=8), duty=4 accepted before the first wrap.
//      -> from the second period raw is high for phases 0..3 (4 of 16 cycles).
//      -> pwm_hi high 3 cycles per period (DEADTIME=1); pwm_lo high 11 cycles per period.
//   2. Offer duty=10 mid-period, then duty=2 while the shadow is full.
//      -> first accepted, duty_ready=0 until period_start.
//      -> 10 applies next period; 2 accepted after that wrap and applies the period after.
//   3. Duty 0, then 16, then 20 (clamp).
//      -> pwm_hi never rises (0); pwm_hi constant 1 with no gaps and no period gaps (16 and 20).
//   4. Inject jc_state=8'b0000_0101 for one cycle.
//      -> code_err pulses once; pwm_hi=pwm_lo=0 around the fault; no period_start.
//      -> normal output resumes on the next legal codes.
//   5. Assert rst_n=1 mid-period with the shadow full.
//      -> all outputs 0 asynchronously, duty_ready=1.
//      -> after release duty_active=0 and only pwm_lo toggles high.
//   6. Sweep DEADTIME=0 and 3 with duty=8; assert pwm_hi & pwm_lo == 0 every cycle.
//      -> gap widths are 0 and 3 cycles exactly.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the Johnson-counter PWM phase generator.
package pwm_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DT_W      = 3;

    // Bits needed to hold a phase index or duty value in 0..2*width.
    function automatic int unsigned phase_bits(input int unsigned width);
        return $clog2(2 * width + 1);
    endfunction

    localparam int unsigned PHASE_W = phase_bits(DEF_WIDTH);

    typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/pwm_phase_gen_deadtime_gen.sv
// Compare-result register plus dead-time insertion for the complementary PWM pair.
module deadtime_gen
    import pwm_pkg::*;
#(
    parameter int unsigned DEADTIME = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
    localparam logic            DT_ZERO = (DEADTIME == 0);

    logic            raw_q;
    logic [DT_W-1:0] gap_cnt;
    logic            edge_c;
    logic            gap_c;

    // A new edge opens a gap (unless DEADTIME is 0); the last counted cycle releases it.
    assign edge_c = raw != raw_q;
    assign gap_c  = edge_c ? ~DT_ZERO : (gap_cnt > DT_W'(1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            raw_q   <= 1'b0;
            gap_cnt <= '0;
            pwm_hi  <= 1'b0;
            pwm_lo  <= 1'b0;
        end else begin
            raw_q <= raw;
            if (edge_c) begin
                gap_cnt <= DT_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - DT_W'(1);
            end
            pwm_hi <= raw & ~gap_c;
            pwm_lo <= ~raw & ~gap_c;
        end
    end

endmodule

// File: rtl/pwm_phase_gen.sv
// Decodes Johnson-counter phase, compares it against a double-buffered duty
// and drives a complementary PWM pair through the dead-time generator.
module pwm_phase_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEADTIME = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              jc_state,
    input  logic [phase_bits(WIDTH)-1:0]  duty,
    input  logic                          duty_valid,
    output logic                          duty_ready,
    output logic                          pwm_hi,
    output logic                          pwm_lo,
    output logic                          period_start,
    output logic                          code_err
);

    localparam int unsigned     PW    = phase_bits(WIDTH);
    localparam int unsigned     P     = 2 * WIDTH;
    localparam logic [PW-1:0]   P_V   = PW'(P);
    localparam logic [PW-1:0]   LAST  = PW'(P - 1);

    logic [PW-1:0]    phase_q;
    logic             code_ok_q;
    logic [PW-1:0]    shadow;
    logic [PW-1:0]    duty_active;

    logic [WIDTH-1:0] fill_c;
    logic [PW-1:0]    ones_c;
    logic [PW-1:0]    dec_phase_c;
    logic             dec_ok_c;
    logic [PW-1:0]    duty_clamp_c;
    logic [PW-1:0]    eff_duty_c;
    logic             raw_c;

    // Fill-form codes (bit 0 set, or all zero) count ones; drain-form codes count back from P.
    always_comb begin
        ones_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones_c = ones_c + PW'(jc_state[i]);
        end
        if (jc_state[0] || (jc_state == '0)) begin
            fill_c      = jc_state;
            dec_phase_c = ones_c;
        end else begin
            fill_c      = ~jc_state;
            dec_phase_c = P_V - ones_c;
        end
        dec_ok_c = (fill_c & (fill_c + WIDTH'(1))) == '0;
    end

    assign duty_clamp_c = (duty > P_V) ? P_V : duty;

    // Phase 0 of a new period already sees the duty being promoted from the shadow.
    assign eff_duty_c = (period_start && !duty_ready) ? shadow : duty_active;
    assign raw_c      = (phase_q < eff_duty_c) & code_ok_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            phase_q      <= '0;
            code_ok_q    <= 1'b0;
            code_err     <= 1'b0;
            period_start <= 1'b0;
            shadow       <= '0;
            duty_active  <= '0;
            duty_ready   <= 1'b1;
        end else begin
            code_err     <= ~dec_ok_c;
            code_ok_q    <= dec_ok_c;
            period_start <= dec_ok_c && (phase_q == LAST) && (dec_phase_c == '0);
            if (dec_ok_c) begin
                phase_q <= dec_phase_c;
            end
            // Promotion and acceptance are exclusive: one needs a full shadow, the other an empty one.
            if (period_start && !duty_ready) begin
                duty_active <= shadow;
                duty_ready  <= 1'b1;
            end else if (duty_valid && duty_ready) begin
                shadow     <= duty_clamp_c;
                duty_ready <= 1'b0;
            end
        end
    end

    deadtime_gen #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw_c),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed bench for pwm_phase_gen: three instances (DEADTIME 1, 0, 3) share one stimulus.
module tb_pwm_phase_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] jc_state;
    logic [4:0] duty;
    logic       duty_valid;

    logic rdy1, hi1, lo1, ps1, err1;
    logic rdy0, hi0, lo0, ps0, err0;
    logic rdy3, hi3, lo3, ps3, err3;

    int checks = 0;
    int errors = 0;

    int ph  = 0;
    logic inj = 1'b0;
    int n_hi1, n_lo1, n_hi0, n_lo0, n_hi3, n_lo3, n_ps1, n_err1, n_rdy1, idx;
    logic [15:0] m0;

    typedef struct {
        int          duty;
        int          hi1, lo1, hi0, lo0, hi3, lo3;
        logic [15:0] m0;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    pwm_phase_gen #(.WIDTH(8), .DEADTIME(1)) u_dt1 (
        .clk(clk), .rst_n(rst_n), .jc_state(jc_state), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(rdy1), .pwm_hi(hi1), .pwm_lo(lo1), .period_start(ps1), .code_err(err1));
    pwm_phase_gen #(.WIDTH(8), .DEADTIME(0)) u_dt0 (
        .clk(clk), .rst_n(rst_n), .jc_state(jc_state), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(rdy0), .pwm_hi(hi0), .pwm_lo(lo0), .period_start(ps0), .code_err(err0));
    pwm_phase_gen #(.WIDTH(8), .DEADTIME(3)) u_dt3 (
        .clk(clk), .rst_n(rst_n), .jc_state(jc_state), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(rdy3), .pwm_hi(hi3), .pwm_lo(lo3), .period_start(ps3), .code_err(err3));

    // Both sides high together is never allowed, on any instance.
    always @(negedge clk) begin
        checks++;
        if ((hi1 & lo1) | (hi0 & lo0) | (hi3 & lo3)) begin
            errors++;
            $display("FAIL overlap at %0t: hi/lo dt1=%b%b dt0=%b%b dt3=%b%b, required never both 1",
                     $time, hi1, lo1, hi0, lo0, hi3, lo3);
        end
    end

    function automatic logic [7:0] jc_of(input int p);
        logic [7:0] v;
        v = 8'h00;
        if (p <= 8) begin
            for (int i = 0; i < p; i++) v[i] = 1'b1;
        end else begin
            v = 8'hFF << (p - 8);
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_hi1 = 0; n_lo1 = 0; n_hi0 = 0; n_lo0 = 0; n_hi3 = 0; n_lo3 = 0;
        n_ps1 = 0; n_err1 = 0; n_rdy1 = 0; idx = 0; m0 = 16'h0000;
    endtask

    // One clock: sample outputs after the edge, then present the next Johnson code.
    task automatic tick();
        @(posedge clk);
        #1;
        n_hi1 += int'(hi1); n_lo1 += int'(lo1);
        n_hi0 += int'(hi0); n_lo0 += int'(lo0);
        n_hi3 += int'(hi3); n_lo3 += int'(lo3);
        n_ps1 += int'(ps1); n_err1 += int'(err1); n_rdy1 += int'(rdy1);
        if (idx < 16 && hi0) m0[idx] = 1'b1;
        idx++;
        ph = (ph + 1) % 16;
        jc_state = inj ? 8'b0000_0101 : jc_of(ph);
        inj = 1'b0;
    endtask

    task automatic offer(input int d, output int waited);
        logic r;
        logic ok;
        ok = 1'b0;
        waited = 0;
        duty = 5'(d);
        duty_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = rdy1;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        duty_valid = 1'b0;
        if (!ok) chk("offer_timeout", 0, 1);
    endtask

    task automatic sync_ps();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ps1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("period_start_timeout", 0, 1);
    endtask

    // Starting on a period_start sample, collect one full period ending on the next one.
    task automatic measure_period();
        clear_counts();
        repeat (16) tick();
        chk("period_aligned", int'(ps1), 1);
    endtask

    initial begin
        int   w;
        int   t_ps;
        int   t_rdy;
        int   first_hi0;
        logic found;

        tbl[0] = '{4,  3, 11,  4, 12,  1,  9, 16'h000F};
        tbl[1] = '{10, 9,  5, 10,  6,  7,  3, 16'h03FF};
        tbl[2] = '{2,  1, 13,  2, 14,  0, 11, 16'h0003};
        tbl[3] = '{0,  0, 16,  0, 16,  0, 16, 16'h0000};
        tbl[4] = '{16, 16, 0, 16,  0, 16,  0, 16'hFFFF};
        tbl[5] = '{20, 16, 0, 16,  0, 16,  0, 16'hFFFF};
        tbl[6] = '{1,  0, 14,  1, 15,  0, 12, 16'h0001};
        tbl[7] = '{15, 14, 0, 15,  1, 12,  0, 16'h7FFF};
        tbl[8] = '{8,  7,  7,  8,  8,  5,  5, 16'h00FF};

        rst_n      = 1'b1;
        jc_state   = 8'h00;
        duty       = 5'd0;
        duty_valid = 1'b0;
        clear_counts();

        // Reset state
        repeat (3) tick();
        chk("rst_hi", int'(hi1), 0);
        chk("rst_lo", int'(lo1), 0);
        chk("rst_ps", int'(ps1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_ready", int'(rdy1), 1);
        rst_n = 1'b0;
        tick();
        chk("post_rst_lo1", int'(lo1), 1);
        chk("post_rst_lo0", int'(lo0), 1);
        chk("post_rst_lo3", int'(lo3), 1);
        chk("post_rst_hi1", int'(hi1), 0);

        // Steady-state duty table across all three dead-times
        for (int v = 0; v < 9; v++) begin
            offer(tbl[v].duty, w);
            sync_ps();
            measure_period();
            measure_period();
            chk($sformatf("d%0d_hi_dt1", tbl[v].duty), n_hi1, tbl[v].hi1);
            chk($sformatf("d%0d_lo_dt1", tbl[v].duty), n_lo1, tbl[v].lo1);
            chk($sformatf("d%0d_hi_dt0", tbl[v].duty), n_hi0, tbl[v].hi0);
            chk($sformatf("d%0d_lo_dt0", tbl[v].duty), n_lo0, tbl[v].lo0);
            chk($sformatf("d%0d_hi_dt3", tbl[v].duty), n_hi3, tbl[v].hi3);
            chk($sformatf("d%0d_lo_dt3", tbl[v].duty), n_lo3, tbl[v].lo3);
            chk($sformatf("d%0d_raw_mask", tbl[v].duty), int'(m0), int'(tbl[v].m0));
            chk($sformatf("d%0d_one_ps", tbl[v].duty), n_ps1, 1);
        end

        // Offer 10 mid-period, then 2 while the shadow is full
        sync_ps();
        repeat (5) tick();
        chk("mid_ready", int'(rdy1), 1);
        offer(10, w);
        chk("acc10_wait", w, 0);
        chk("shadow_full_ready", int'(rdy1), 0);
        duty = 5'd2;
        duty_valid = 1'b1;
        t_ps = -1;
        t_rdy = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ps1 && t_ps < 0) t_ps = i;
            if (rdy1) begin
                t_rdy = i;
                break;
            end
        end
        chk("ready_after_ps", t_rdy, t_ps + 1);
        first_hi0 = int'(hi0);
        clear_counts();
        offer(2, w);
        chk("acc2_wait", w, 0);
        repeat (14) tick();
        chk("duty10_period_hi0", first_hi0 + n_hi0, 10);
        chk("duty10_period_end", int'(ps1), 1);
        measure_period();
        chk("duty2_period_hi0", n_hi0, 2);
        chk("duty2_period_hi1", n_hi1, 1);

        // Illegal code injected in place of phase 0
        offer(16, w);
        sync_ps();
        measure_period();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ph == 15) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("inject_align", int'(found), 1);
        inj = 1'b1;
        clear_counts();
        repeat (10) tick();
        chk("fault_code_err", n_err1, 1);
        chk("fault_no_ps", n_ps1, 0);
        chk("fault_hi_dt1", n_hi1, 8);
        chk("fault_lo_dt1", n_lo1, 0);
        chk("fault_hi_dt0", n_hi0, 9);
        sync_ps();
        measure_period();
        chk("resume_hi_dt1", n_hi1, 16);
        chk("resume_err", n_err1, 0);

        // Asynchronous reset mid-period with the shadow full
        offer(10, w);
        chk("pre_rst_full", int'(rdy1), 0);
        repeat (3) tick();
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_rst_hi", int'(hi1), 0);
        chk("async_rst_lo", int'(lo1), 0);
        chk("async_rst_ps", int'(ps1), 0);
        chk("async_rst_err", int'(err1), 0);
        chk("async_rst_ready", int'(rdy1), 1);
        repeat (2) tick();
        rst_n = 1'b0;
        clear_counts();
        repeat (32) tick();
        chk("after_rst_hi_dt1", n_hi1, 0);
        chk("after_rst_hi_dt0", n_hi0, 0);
        chk("after_rst_lo_dt1", n_lo1, 32);
        chk("after_rst_ready", n_rdy1, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
